disp_16hex_monitor: RTL and testbench

- Receive-side model of the labkit 16-character dot-matrix display serial interface.
- Oversamples the driver pins (disp_clock, disp_data_out, disp_rs, disp_ce_b, disp_reset_b) on clock_27mhz.
- Rebuilds the 640-bit dot register and the 32-bit control register, then decodes each 40-dot character back to a hex nibble, or to blank / fully-lit flags.
- Used as a loopback checker beside the central FSM's display driver, and as a bench monitor.

---
 rtl/disp_16hex_monitor_pkg.sv | 16 +
 rtl/disp_16hex_monitor_if.sv | 13 +
 rtl/disp_16hex_monitor_glyph_decode.sv | 27 ++
 rtl/disp_16hex_monitor.sv | 159 +++++++++++++++
 tb/tb_disp_16hex_monitor.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/disp_16hex_monitor_pkg.sv
// rtl/disp_16hex_monitor_pkg.sv - shared widths and the display font for the dot-matrix monitor
package disp_mon_pkg;

  localparam int DOT_BITS   = 640;
  localparam int CTRL_BITS  = 32;
  localparam int GLYPH_BITS = 40;

  // Five 8-bit columns per glyph, leftmost column in the top byte; must track the driver's font
  localparam logic [GLYPH_BITS-1:0] GLYPH_HEX [16] = '{
    40'h3E_51_49_45_3E, 40'h00_42_7F_40_00, 40'h62_51_49_49_46, 40'h22_41_49_49_36,
    40'h18_14_12_7F_10, 40'h27_45_45_45_39, 40'h3C_4A_49_49_30, 40'h01_71_09_05_03,
    40'h36_49_49_49_36, 40'h06_49_49_29_1E, 40'h7E_09_09_09_7E, 40'h7F_49_49_49_36,
    40'h3E_41_41_41_22, 40'h7F_41_41_41_3E, 40'h7F_49_49_49_41, 40'h7F_09_09_09_01
  };

endpackage

// File: rtl/disp_16hex_monitor_if.sv
// rtl/disp_16hex_monitor_if.sv - serial pin bundle between the display driver and its monitor
interface disp_16hex_monitor_if;

  logic disp_clock;
  logic disp_data_out;
  logic disp_rs;
  logic disp_ce_b;
  logic disp_reset_b;

  modport master (output disp_clock, disp_data_out, disp_rs, disp_ce_b, disp_reset_b);
  modport slave  (input  disp_clock, disp_data_out, disp_rs, disp_ce_b, disp_reset_b);

endinterface

// File: rtl/disp_16hex_monitor_glyph_decode.sv
// rtl/disp_16hex_monitor_glyph_decode.sv - maps one 40-dot character to a hex nibble or blank/lit flags
module disp_glyph_decode
  import disp_mon_pkg::*;
(
  input  logic [GLYPH_BITS-1:0] dots,
  output logic [3:0]            nibble,
  output logic                  valid,
  output logic                  blank,
  output logic                  lit
);

  always_comb begin
    nibble = 4'd0;
    valid  = 1'b0;
    lit    = &dots;
    blank  = ~|dots;
    if (!lit && !blank) begin
      for (int i = 0; i < 16; i++) begin
        if (dots == GLYPH_HEX[i]) begin
          nibble = 4'(i);
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/disp_16hex_monitor.sv
// rtl/disp_16hex_monitor.sv - oversampling receiver that rebuilds and decodes the display registers
// Optional latch-time bit-count checking is enabled by DISP_MON_BITCHECK_EN.
module disp_16hex_monitor
  import disp_mon_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int NUM_CHARS     = DOT_BITS / GLYPH_BITS,
  parameter int DOTS_PER_CHAR = GLYPH_BITS
) (
  input  logic                   clock_27mhz,
  input  logic                   reset_b,
  disp_16hex_monitor_if.slave    disp,
  output logic [4*NUM_CHARS-1:0] hex_data,
  output logic [NUM_CHARS-1:0]   glyph_valid,
  output logic [NUM_CHARS-1:0]   blank_flags,
  output logic [NUM_CHARS-1:0]   lit_flags,
  output logic [CTRL_BITS-1:0]   control_word,
  output logic                   frame_strobe,
  output logic                   ctrl_strobe,
  output logic                   frame_error
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int DOT_W  = NUM_CHARS * DOTS_PER_CHAR;
  localparam int CNT_W  = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // Pin order {reset_b, ce_b, rs, data, clock}; idle is reset released, deselected, clock high
  localparam logic [4:0] PIN_IDLE = 5'b11001;

  logic [4:0]             pins_raw;
  logic [4:0]             sync_q [SYNC_N];
  logic [1:0]             edge_q;
  logic                   s_clock, s_data, s_rs, s_ce_b, s_reset_b;
  logic                   clk_rise, ce_rise, shift_en, latch_en;

  logic [DOT_W-1:0]       dot_shift, dot_shift_nxt, dot_latch;
  logic [CTRL_BITS-1:0]   ctrl_shift, ctrl_shift_nxt;
  logic [CNT_W-1:0]       bit_count, count_nxt;
  logic                   last_rs, last_rs_nxt;
  logic                   decode_pending;

  logic [4*NUM_CHARS-1:0] dec_nibble;
  logic [NUM_CHARS-1:0]   dec_valid, dec_blank, dec_lit;

  assign pins_raw = {disp.disp_reset_b, disp.disp_ce_b, disp.disp_rs, disp.disp_data_out, disp.disp_clock};
  assign {s_reset_b, s_ce_b, s_rs, s_data, s_clock} = sync_q[SYNC_N-1];

  assign clk_rise = s_clock & ~edge_q[0];
  assign ce_rise  = s_ce_b & ~edge_q[1];
  // A clock edge arriving together with ce_b's rise still belongs to the frame being closed
  assign shift_en = clk_rise & (~s_ce_b | ~edge_q[1]);
  assign latch_en = ce_rise & (count_nxt != '0);

  always_ff @(posedge clock_27mhz or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < SYNC_N; i++) sync_q[i] <= PIN_IDLE;
      edge_q <= 2'b11;
    end else begin
      sync_q[0] <= pins_raw;
      for (int i = 1; i < SYNC_N; i++) sync_q[i] <= sync_q[i-1];
      edge_q <= {s_ce_b, s_clock};
    end
  end

  always_comb begin
    dot_shift_nxt  = dot_shift;
    ctrl_shift_nxt = ctrl_shift;
    count_nxt      = bit_count;
    last_rs_nxt    = last_rs;
    if (shift_en) begin
      if (s_rs) ctrl_shift_nxt = {ctrl_shift[CTRL_BITS-2:0], s_data};
      else      dot_shift_nxt  = {dot_shift[DOT_W-2:0], s_data};
      last_rs_nxt = s_rs;
      if (bit_count != CNT_MAX) count_nxt = bit_count + CNT_W'(1);
    end
  end

  // Latch target follows last_rs: the driver may flip rs on the same edge it raises ce_b
  always_ff @(posedge clock_27mhz or negedge reset_b) begin
    if (!reset_b) begin
      dot_shift      <= '0;
      ctrl_shift     <= '0;
      bit_count      <= '0;
      last_rs        <= 1'b0;
      dot_latch      <= '0;
      control_word   <= '0;
      ctrl_strobe    <= 1'b0;
      decode_pending <= 1'b0;
    end else if (!s_reset_b) begin
      dot_shift      <= '0;
      ctrl_shift     <= '0;
      bit_count      <= '0;
      last_rs        <= 1'b0;
      dot_latch      <= '0;
      control_word   <= '0;
      ctrl_strobe    <= 1'b0;
      decode_pending <= 1'b0;
    end else begin
      dot_shift      <= dot_shift_nxt;
      ctrl_shift     <= ctrl_shift_nxt;
      last_rs        <= last_rs_nxt;
      bit_count      <= ce_rise ? '0 : count_nxt;
      ctrl_strobe    <= latch_en & last_rs_nxt;
      decode_pending <= latch_en & ~last_rs_nxt;
      if (latch_en) begin
        if (last_rs_nxt) control_word <= ctrl_shift_nxt;
        else             dot_latch    <= dot_shift_nxt;
      end
    end
  end

  for (genvar k = 0; k < NUM_CHARS; k++) begin : g_char
    disp_glyph_decode u_decode (
      .dots   (dot_latch[k*DOTS_PER_CHAR +: GLYPH_BITS]),
      .nibble (dec_nibble[4*k +: 4]),
      .valid  (dec_valid[k]),
      .blank  (dec_blank[k]),
      .lit    (dec_lit[k])
    );
  end

  always_ff @(posedge clock_27mhz or negedge reset_b) begin
    if (!reset_b) begin
      hex_data     <= '0;
      glyph_valid  <= '0;
      blank_flags  <= '0;
      lit_flags    <= '0;
      frame_strobe <= 1'b0;
    end else if (!s_reset_b) begin
      hex_data     <= '0;
      glyph_valid  <= '0;
      blank_flags  <= '1;
      lit_flags    <= '0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= decode_pending;
      if (decode_pending) begin
        hex_data    <= dec_nibble;
        glyph_valid <= dec_valid;
        blank_flags <= dec_blank;
        lit_flags   <= dec_lit;
      end
    end
  end

`ifdef DISP_MON_BITCHECK_EN
  logic [CNT_W-1:0] count_expect;
  assign count_expect = last_rs_nxt ? CNT_W'(CTRL_BITS) : CNT_W'(DOT_W);

  always_ff @(posedge clock_27mhz or negedge reset_b) begin
    if (!reset_b)                                frame_error <= 1'b0;
    else if (!s_reset_b)                         frame_error <= 1'b0;
    else if (latch_en && count_nxt != count_expect) frame_error <= 1'b1;
  end
`else
  assign frame_error = 1'b0;
`endif

endmodule

// File: tb/tb_disp_16hex_monitor.sv
// tb/tb_disp_16hex_monitor.sv - self-checking bench for disp_16hex_monitor
module tb_disp_16hex_monitor;

  localparam int SYNC = 2;
`ifdef DISP_MON_BITCHECK_EN
  localparam bit BITCHECK = 1'b1;
`else
  localparam bit BITCHECK = 1'b0;
`endif

  localparam logic [39:0] FONT [16] = '{
    40'h3E_51_49_45_3E, 40'h00_42_7F_40_00, 40'h62_51_49_49_46, 40'h22_41_49_49_36,
    40'h18_14_12_7F_10, 40'h27_45_45_45_39, 40'h3C_4A_49_49_30, 40'h01_71_09_05_03,
    40'h36_49_49_49_36, 40'h06_49_49_29_1E, 40'h7E_09_09_09_7E, 40'h7F_49_49_49_36,
    40'h3E_41_41_41_22, 40'h7F_41_41_41_3E, 40'h7F_49_49_49_41, 40'h7F_09_09_09_01
  };

  // char codes: 0-15 hex glyph, 16 all zeros, 17 all ones, 18 single dot, 19 random dots
  typedef struct {
    logic [15:0][4:0] codes;
    logic [63:0]      hex;
    logic [15:0]      valid;
    logic [15:0]      blank;
    logic [15:0]      lit;
  } vec_t;

  logic clk = 1'b0;
  logic rst_b;
  logic [63:0] hex_data;
  logic [15:0] glyph_valid, blank_flags, lit_flags;
  logic [31:0] control_word;
  logic frame_strobe, ctrl_strobe, frame_error;

  disp_16hex_monitor_if dif ();

  disp_16hex_monitor #(.SYNC_STAGES(SYNC), .NUM_CHARS(16), .DOTS_PER_CHAR(40)) dut (
    .clock_27mhz  (clk),
    .reset_b      (rst_b),
    .disp         (dif),
    .hex_data     (hex_data),
    .glyph_valid  (glyph_valid),
    .blank_flags  (blank_flags),
    .lit_flags    (lit_flags),
    .control_word (control_word),
    .frame_strobe (frame_strobe),
    .ctrl_strobe  (ctrl_strobe),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int frame_cnt = 0;
  int ctrl_cnt = 0;
  int lat;
  bit tx_bits[$];

  bit dot_hist[$];
  bit ctl_hist[$];
  int m_count, m_fs, m_cs;
  bit m_last_rs, m_ferr;
  logic [63:0] m_hex;
  logic [15:0] m_valid, m_blank, m_lit;
  logic [31:0] m_ctrl;

  vec_t vec [4];
  logic [15:0][4:0] codes;

  always @(negedge clk) begin
    if (frame_strobe) frame_cnt <= frame_cnt + 1;
    if (ctrl_strobe)  ctrl_cnt  <= ctrl_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no summary, expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] code_pattern(input logic [4:0] code);
    logic [63:0] r;
    case (code)
      5'd16: return 40'h0;
      5'd17: return {40{1'b1}};
      5'd18: return 40'h1;
      5'd19: begin r = {$urandom, $urandom}; return r[39:0]; end
      default: return FONT[code[3:0]];
    endcase
  endfunction

  task automatic build_frame(input logic [15:0][4:0] c);
    logic [39:0] p;
    tx_bits.delete();
    for (int k = 15; k >= 0; k--) begin
      p = code_pattern(c[k]);
      for (int b = 39; b >= 0; b--) tx_bits.push_back(p[b]);
    end
  endtask

  task automatic build_word(input logic [31:0] w);
    tx_bits.delete();
    for (int b = 31; b >= 0; b--) tx_bits.push_back(w[b]);
  endtask

  task automatic random_codes();
    for (int k = 0; k < 16; k++) codes[k] = 5'($urandom_range(0, 19));
  endtask

  task automatic model_clear(input bit by_disp_reset);
    dot_hist.delete();
    ctl_hist.delete();
    m_count = 0; m_last_rs = 1'b0; m_ctrl = '0; m_ferr = 1'b0;
    m_hex = '0; m_valid = '0; m_lit = '0;
    m_blank = by_disp_reset ? 16'hFFFF : 16'h0000;
  endtask

  task automatic model_shift(input bit rs, input bit d);
    if (rs) begin
      ctl_hist.push_back(d);
      if (ctl_hist.size() > 32) void'(ctl_hist.pop_front());
    end else begin
      dot_hist.push_back(d);
      if (dot_hist.size() > 640) void'(dot_hist.pop_front());
    end
    m_count++;
    m_last_rs = rs;
  endtask

  // The register image is simply the most recent bits received, oldest first, zero-padded.
  task automatic model_latch();
    logic [39:0] pat;
    logic [31:0] w;
    int pad, idx;
    if (m_count == 0) return;
    if (BITCHECK && m_count != (m_last_rs ? 32 : 640)) m_ferr = 1'b1;
    if (m_last_rs) begin
      w = '0;
      pad = 32 - ctl_hist.size();
      for (int i = 0; i < 32; i++) w = {w[30:0], (i < pad) ? 1'b0 : ctl_hist[i-pad]};
      m_ctrl = w;
      m_cs++;
    end else begin
      pad = 640 - dot_hist.size();
      for (int k = 0; k < 16; k++) begin
        for (int b = 0; b < 40; b++) begin
          idx = (15 - k) * 40 + b;
          pat[39-b] = (idx < pad) ? 1'b0 : dot_hist[idx-pad];
        end
        m_hex[4*k +: 4] = 4'h0;
        m_valid[k] = 1'b0; m_blank[k] = 1'b0; m_lit[k] = 1'b0;
        if (pat == {40{1'b1}}) m_lit[k] = 1'b1;
        else if (pat == 40'h0) m_blank[k] = 1'b1;
        else for (int g = 0; g < 16; g++)
          if (pat == FONT[g]) begin m_valid[k] = 1'b1; m_hex[4*k +: 4] = 4'(g); end
      end
      m_fs++;
    end
    m_count = 0;
  endtask

  task automatic send_bit(input bit rs, input bit d, input bit with_ce);
    @(negedge clk);
    dif.disp_clock = 1'b0; dif.disp_rs = rs; dif.disp_data_out = d;
    repeat (2) @(negedge clk);
    dif.disp_clock = 1'b1;
    if (with_ce) dif.disp_ce_b = 1'b1;
    model_shift(rs, d);
    @(negedge clk);
  endtask

  task automatic send_frame(input bit rs, input int nbits, input bit rs_flip, input bit merge);
    @(negedge clk);
    dif.disp_ce_b = 1'b0; dif.disp_rs = rs;
    repeat (2) @(negedge clk);
    for (int i = 0; i < nbits; i++) send_bit(rs, tx_bits[i], merge && (i == nbits - 1));
    if (!(merge && nbits > 0)) begin
      @(negedge clk);
      dif.disp_ce_b = 1'b1;
      if (rs_flip) dif.disp_rs = ~rs;
    end
    model_latch();
    lat = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (frame_strobe && lat == 0) lat = i;
    end
    dif.disp_rs = 1'b0;
  endtask

  task automatic disp_reset_pulse();
    @(negedge clk);
    dif.disp_reset_b = 1'b0;
    repeat (4) @(negedge clk);
    dif.disp_reset_b = 1'b1;
    repeat (4) @(negedge clk);
    model_clear(1'b1);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " hex_data"}, hex_data, m_hex);
    chk({tag, " glyph_valid"}, 64'(glyph_valid), 64'(m_valid));
    chk({tag, " blank_flags"}, 64'(blank_flags), 64'(m_blank));
    chk({tag, " lit_flags"}, 64'(lit_flags), 64'(m_lit));
    chk({tag, " control_word"}, 64'(control_word), 64'(m_ctrl));
    chk({tag, " frame_error"}, 64'(frame_error), 64'(m_ferr));
    chk({tag, " frame_strobes"}, 64'(frame_cnt), 64'(m_fs));
    chk({tag, " ctrl_strobes"}, 64'(ctrl_cnt), 64'(m_cs));
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      vec[0].codes[k] = 5'(15 - k);
      vec[1].codes[k] = (k == 3) ? 5'd17 : (k == 7) ? 5'd16 : 5'd5;
      vec[2].codes[k] = (k == 0) ? 5'd18 : 5'd10;
      vec[3].codes[k] = 5'd16;
    end
    vec[0].hex = 64'h0123456789ABCDEF; vec[0].valid = 16'hFFFF; vec[0].blank = 16'h0000; vec[0].lit = 16'h0000;
    vec[1].hex = 64'h5555555505550555; vec[1].valid = 16'hFF77; vec[1].blank = 16'h0080; vec[1].lit = 16'h0008;
    vec[2].hex = 64'hAAAAAAAAAAAAAAA0; vec[2].valid = 16'hFFFE; vec[2].blank = 16'h0000; vec[2].lit = 16'h0000;
    vec[3].hex = 64'h0;                vec[3].valid = 16'h0000; vec[3].blank = 16'hFFFF; vec[3].lit = 16'h0000;

    dif.disp_clock = 1'b1; dif.disp_data_out = 1'b0; dif.disp_rs = 1'b0;
    dif.disp_ce_b = 1'b1; dif.disp_reset_b = 1'b1;
    rst_b = 1'b0;
    m_fs = 0; m_cs = 0;
    model_clear(1'b0);
    repeat (3) @(negedge clk);
    chk_model("reset");
    chk("reset frame_strobe", 64'(frame_strobe), 64'd0);
    chk("reset ctrl_strobe", 64'(ctrl_strobe), 64'd0);
    rst_b = 1'b1;
    repeat (2) @(negedge clk);

    disp_reset_pulse();
    chk_model("disp_reset");

    for (int k = 0; k < 16; k++) codes[k] = 5'd16;
    build_frame(codes);
    send_frame(1'b0, 640, 1'b0, 1'b0);
    chk_model("init_zeros");
    chk("init_zeros blank_flags", 64'(blank_flags), 64'hFFFF);

    build_word(32'h7F7F7F7F);
    send_frame(1'b1, 32, 1'b0, 1'b0);
    chk("init control_word", 64'(control_word), 64'h7F7F7F7F);
    chk_model("init_ctrl");

    for (int v = 0; v < 4; v++) begin
      int fs0;
      fs0 = frame_cnt;
      build_frame(vec[v].codes);
      send_frame(1'b0, 640, 1'b0, 1'b0);
      chk($sformatf("vec%0d hex_data", v), hex_data, vec[v].hex);
      chk($sformatf("vec%0d glyph_valid", v), 64'(glyph_valid), 64'(vec[v].valid));
      chk($sformatf("vec%0d blank_flags", v), 64'(blank_flags), 64'(vec[v].blank));
      chk($sformatf("vec%0d lit_flags", v), 64'(lit_flags), 64'(vec[v].lit));
      chk($sformatf("vec%0d strobe_count", v), 64'(frame_cnt - fs0), 64'd1);
      chk($sformatf("vec%0d latency", v), 64'(lat), 64'(SYNC + 2));
    end

    random_codes(); build_frame(codes);
    send_frame(1'b0, 640, 1'b1, 1'b0);
    chk_model("rs_flip");

    random_codes(); build_frame(codes);
    send_frame(1'b0, 640, 1'b0, 1'b1);
    chk_model("clk_ce_same_edge");

    send_frame(1'b0, 0, 1'b0, 1'b0);
    send_frame(1'b1, 0, 1'b0, 1'b0);
    chk_model("zero_count");

    random_codes(); build_frame(codes);
    send_frame(1'b0, 639, 1'b0, 1'b0);
    chk_model("short_frame");
    chk("short_frame frame_error", 64'(frame_error), 64'(BITCHECK));
    random_codes(); build_frame(codes);
    send_frame(1'b0, 640, 1'b0, 1'b0);
    chk_model("after_short");
    disp_reset_pulse();
    chk_model("error_cleared");

    random_codes(); build_frame(codes);
    @(negedge clk);
    dif.disp_ce_b = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 300; i++) send_bit(1'b0, tx_bits[i], 1'b0);
    rst_b = 1'b0;
    #1;
    model_clear(1'b0);
    chk_model("reset_mid_frame");
    chk("reset_mid_frame frame_strobe", 64'(frame_strobe), 64'd0);
    dif.disp_ce_b = 1'b1; dif.disp_clock = 1'b1;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    random_codes(); build_frame(codes);
    send_frame(1'b0, 640, 1'b0, 1'b0);
    chk_model("post_reset_frame");

    for (int r = 0; r < 3; r++) begin
      random_codes(); build_frame(codes);
      send_frame(1'b0, 640, 1'b0, 1'b0);
      chk_model($sformatf("random_frame%0d", r));
    end
    for (int r = 0; r < 2; r++) begin
      build_word($urandom);
      send_frame(1'b1, 32, 1'b0, 1'b0);
      chk_model($sformatf("random_ctrl%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
